c_result_writer: RTL
====================

// Module: c_result_writer
//
// PURPOSE
//   Write-side counterpart of the A/B operand fetch path. Takes C result elements streamed out of
//   the array results controller and packs them into bus-width words. Assigns each word its
//   row-major C address from base_addr_c and pushes (address, data) pairs into the C write FIFO.
//   The c_bus memory_ctrl drains that FIFO with w_en_i=1.
//   Reports completion once every one of m*p elements has been written into the FIFO.
//
// PARAMETERS
//   ELEM_WIDTH       16   bits per C element (2 x operand width)
//   IN_LANES         4    max elements per input beat (= ARRAY_WIDTH); must be <= WORD_ELEMS
//   BUS_WIDTH_BYTES  32   bytes per memory word; WORD_ELEMS = BUS_WIDTH_BYTES*8/ELEM_WIDTH (16)
//   ADDRESS_WIDTH    16   memory address width
//
// PORTS
//   clk          in   1                     clock
//   reset        in   1                     synchronous reset, active-high
//   start_i      in   1                     start pulse; latches m, p, base_addr_c
//   m            in   16                    C rows
//   p            in   16                    C columns
//   base_addr_c  in   ADDRESS_WIDTH         byte address of C[0][0]
//   data_i       in   IN_LANES*ELEM_WIDTH   result elements, lane 0 in LSBs = earliest element
//   cnt_i        in   $clog2(IN_LANES+1)    number of valid low lanes in data_i
//   valid_i      in   1                     beat valid
//   ready_o      out  1                     beat accepted when valid_i & ready_o
//   fifo_addr_o  out  ADDRESS_WIDTH         word address to write FIFO
//   fifo_data_o  out  BUS_WIDTH_BYTES*8     packed word, element 0 in LSBs
//   fifo_incr_o  out  1                     push strobe, 1 cycle per word
//   fifo_full_i  in   1                     write FIFO full
//   busy_o       out  1                     state != IDLE
//   done_o       out  1                     1-cycle pulse once the last word has been pushed
//
// BEHAVIOUR
//   Reset
//   - All state is cleared: ready_o, fifo_incr_o, busy_o and done_o are 0.
//   - fifo_addr_o, fifo_data_o, fill and the element/word counters are 0.
//   - Reset asserted mid-operation abandons the job. No flush; FIFO pushes stop the next cycle.
//
//   State machine (IDLE, RUN, FLUSH, DONE)
//   - IDLE: on start_i, latch base and total = m*p (32-bit, no truncation).
//     - total == 0 -> DONE.
//     - otherwise -> RUN.
//   - IDLE: start_i is ignored in every other state.
//   - RUN -> FLUSH when received == total.
//   - FLUSH: if fill > 0, push one zero-padded word when !fifo_full_i; stay in FLUSH until pushed.
//     Then -> DONE.
//   - DONE: done_o = 1 for exactly one cycle, then -> IDLE.
//
//   Packing
//   - Accumulator holds 2*WORD_ELEMS elements; fill is its element count.
//   - ready_o = (state==RUN) & (fill < WORD_ELEMS). Purely combinational, no buffering beyond the accumulator.
//   - Effective count per beat: eff = min(cnt_i, IN_LANES, total - received).
//     - Excess lanes are dropped.
//     - cnt_i = 0 is accepted with no effect.
//   - On an accepted beat, lanes 0..eff-1 are written at accumulator positions fill..fill+eff-1.
//   - Push condition: fill >= WORD_ELEMS and !fifo_full_i.
//     - Pushes elements 0..WORD_ELEMS-1 and shifts the remainder down.
//     - fifo_incr_o is a registered strobe with fifo_addr_o/fifo_data_o valid in the same cycle.
//   - Accept and push may happen in the same cycle. Fill update = fill + eff - (push ? WORD_ELEMS : 0).
//   - Elements in the accumulator never exceed 2*WORD_ELEMS.
//   - Padding lanes of the final partial word are zero.
//   - fifo_full_i held high: no push and no element lost.
//     - ready_o stays low while fill >= WORD_ELEMS.
//
//   Addressing
//   - Word k goes to base + k*BUS_WIDTH_BYTES, truncated to ADDRESS_WIDTH.
//   - Wrap-around modulo 2^ADDRESS_WIDTH is intentional, not an error.
//   - The word counter is 16-bit and is cleared on start.
//   - C is packed contiguously; rows do not restart on a word boundary.
//
//   Latency
//   - First push is 1 cycle after the beat that brings fill to >= WORD_ELEMS, given the FIFO is not full.
//   - done_o follows the last push by 1 cycle.
//
// STRUCTURE
//   Shared package (matmul_pkg)
//   - cw_state_t enum {IDLE, RUN, FLUSH, DONE}
//   - ADDRESS_WIDTH
//   - function word_elems(bus_bytes, elem_width)
//   Sub-module c_word_packer
//   - Holds the accumulator, fill, insert/shift logic and the zero-padding mux.
//   Top-level c_result_writer
//   - Holds the FSM, counters and address generation.
//
// TESTING
//   1. m=2, p=8, base=0x0100, 4 beats of cnt=4, values 1..16
//      -> one push: addr 0x0100, elems 1..16; done_o the following cycle.
//   2. m=3, p=3, 3 beats of cnt=3 (values 1..9)
//      -> FLUSH pushes one word: addr base, elems 1..9, elems 9..15 = 0; done_o once.
//   3. m=4, p=10, 10 beats of cnt=4
//      -> 3 pushes at base, base+0x20, base+0x40; the third word holds 8 elements plus zero padding.
//   4. fifo_full_i high for 20 cycles in RUN
//      -> no fifo_incr_o and ready_o low once fill >= 16.
//      -> after release, all elements arrive in order with no loss or duplication.
//   5. base=0xFFE0, m=2, p=24 -> pushes at 0xFFE0, 0x0000, 0x0020; m=0 -> done_o with zero pushes.
//   6. reset pulsed mid-RUN, then a new start with m=1, p=16
//      -> no stale elements; one push at the new base with the new data.

Source files
------------

// File: rtl/matmul_pkg.sv
//------------------------------------------------------------------------------
// Module   : matmul_pkg
// Brief    : Shared types and helpers for the matmul C write path.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package matmul_pkg;

  localparam int ADDRESS_WIDTH = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } cw_state_t;

  function automatic int word_elems(input int bus_bytes, input int elem_width);
    return (bus_bytes * 8) / elem_width;
  endfunction

endpackage

`default_nettype wire

// File: rtl/c_result_writer_if.sv
//------------------------------------------------------------------------------
// Module   : c_result_writer_if
// Brief    : Job control, result-beat and write-FIFO signals of the C writer.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface c_result_writer_if
  import matmul_pkg::*;
#(
  parameter int ELEM_WIDTH      = 16,
  parameter int IN_LANES        = 4,
  parameter int BUS_WIDTH_BYTES = 32,
  parameter int ADDRESS_WIDTH   = matmul_pkg::ADDRESS_WIDTH
);

  localparam int c_cnt_w = $clog2(IN_LANES + 1);

  logic                            start_i;
  logic [15:0]                     m;
  logic [15:0]                     p;
  logic [ADDRESS_WIDTH-1:0]        base_addr_c;
  logic [IN_LANES*ELEM_WIDTH-1:0]  data_i;
  logic [c_cnt_w-1:0]              cnt_i;
  logic                            valid_i;
  logic                            ready_o;
  logic [ADDRESS_WIDTH-1:0]        fifo_addr_o;
  logic [BUS_WIDTH_BYTES*8-1:0]    fifo_data_o;
  logic                            fifo_incr_o;
  logic                            fifo_full_i;
  logic                            busy_o;
  logic                            done_o;

  modport master (
    output start_i, m, p, base_addr_c, data_i, cnt_i, valid_i, fifo_full_i,
    input  ready_o, fifo_addr_o, fifo_data_o, fifo_incr_o, busy_o, done_o
  );

  modport slave (
    input  start_i, m, p, base_addr_c, data_i, cnt_i, valid_i, fifo_full_i,
    output ready_o, fifo_addr_o, fifo_data_o, fifo_incr_o, busy_o, done_o
  );

endinterface

`default_nettype wire

// File: rtl/c_result_writer_packer.sv
//------------------------------------------------------------------------------
// Module   : c_word_packer
// Brief    : Element accumulator: inserts result lanes, emits bus-width words.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module c_word_packer
  import matmul_pkg::*;
#(
  parameter int ELEM_WIDTH = 16,
  parameter int IN_LANES   = 4,
  parameter int WORD_ELEMS = 16,
  parameter int CNT_W      = $clog2(IN_LANES + 1),
  parameter int FILL_W     = $clog2(2 * WORD_ELEMS + 1)
) (
  input  wire logic                            clk,
  input  wire logic                            reset,
  input  wire logic                            clear,
  input  wire logic [IN_LANES*ELEM_WIDTH-1:0]  data_in,
  input  wire logic [CNT_W-1:0]                eff,
  input  wire logic                            push,
  output logic      [FILL_W-1:0]               fill,
  output logic      [FILL_W-1:0]               fill_sum,
  output logic      [FILL_W-1:0]               fill_nxt,
  output logic      [WORD_ELEMS*ELEM_WIDTH-1:0] word
);

  localparam int c_acc_w = 2 * WORD_ELEMS * ELEM_WIDTH;
  localparam logic [FILL_W-1:0] c_word_fill = FILL_W'(WORD_ELEMS);

  logic [c_acc_w-1:0] r_acc;
  logic [FILL_W-1:0]  r_fill;
  logic [c_acc_w-1:0] w_merged;
  logic [c_acc_w-1:0] w_acc_nxt;
  logic [FILL_W-1:0]  w_drop;

  // Slots at or above fill are kept zero, so the emitted word is already padded.
  always_comb begin
    w_merged = r_acc;
    for (int i = 0; i < IN_LANES; i++) begin
      if ((i < int'(eff)) && ((int'(r_fill) + i) < 2 * WORD_ELEMS)) begin
        w_merged[(int'(r_fill) + i)*ELEM_WIDTH +: ELEM_WIDTH] = data_in[i*ELEM_WIDTH +: ELEM_WIDTH];
      end
    end
  end

  always_comb begin
    fill_sum  = r_fill + FILL_W'(eff);
    w_drop    = '0;
    w_acc_nxt = w_merged;
    if (push) begin
      w_drop    = (fill_sum > c_word_fill) ? c_word_fill : fill_sum;
      w_acc_nxt = w_merged >> (WORD_ELEMS * ELEM_WIDTH);
    end
    fill_nxt = fill_sum - w_drop;
  end

  assign word = w_merged[WORD_ELEMS*ELEM_WIDTH-1:0];
  assign fill = r_fill;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      r_acc  <= '0;
      r_fill <= '0;
    end else begin
      r_acc  <= w_acc_nxt;
      r_fill <= fill_nxt;
    end
  end

endmodule

`default_nettype wire

// File: rtl/c_result_writer.sv
//------------------------------------------------------------------------------
// Module   : c_result_writer
// Brief    : Packs streamed C elements into words and pushes (addr, data) pairs.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module c_result_writer
  import matmul_pkg::*;
#(
  parameter int ELEM_WIDTH      = 16,
  parameter int IN_LANES        = 4,
  parameter int BUS_WIDTH_BYTES = 32,
  parameter int ADDRESS_WIDTH   = matmul_pkg::ADDRESS_WIDTH
) (
  input wire logic           clk,
  input wire logic           reset,
  c_result_writer_if.slave   bus
);

  localparam int c_word_elems = word_elems(BUS_WIDTH_BYTES, ELEM_WIDTH);
  localparam int c_cnt_w      = $clog2(IN_LANES + 1);
  localparam int c_fill_w     = $clog2(2 * c_word_elems + 1);
  localparam int c_word_w     = BUS_WIDTH_BYTES * 8;
  localparam logic [c_cnt_w-1:0]  c_lanes     = c_cnt_w'(IN_LANES);
  localparam logic [c_fill_w-1:0] c_word_fill = c_fill_w'(c_word_elems);

  cw_state_t                r_state;
  cw_state_t                w_state_nxt;
  logic [31:0]              r_total;
  logic [31:0]              r_received;
  logic [ADDRESS_WIDTH-1:0] r_base;
  logic [15:0]              r_word_cnt;
  logic                     r_incr;
  logic                     r_done;
  logic [ADDRESS_WIDTH-1:0] r_addr;
  logic [c_word_w-1:0]      r_data;

  logic                     w_start;
  logic [31:0]              w_start_total;
  logic [31:0]              w_remaining;
  logic [31:0]              w_received_nxt;
  logic                     w_ready;
  logic                     w_accept;
  logic [c_cnt_w-1:0]       w_eff_cap;
  logic [c_cnt_w-1:0]       w_eff;
  logic                     w_push;
  logic [c_fill_w-1:0]      w_fill;
  logic [c_fill_w-1:0]      w_fill_sum;
  logic [c_fill_w-1:0]      w_fill_nxt;
  logic [c_word_w-1:0]      w_word;
  logic [ADDRESS_WIDTH-1:0] w_addr;

  assign w_start        = (r_state == IDLE) && bus.start_i;
  assign w_start_total  = 32'(bus.m) * 32'(bus.p);
  assign w_remaining    = r_total - r_received;
  assign w_ready        = (r_state == RUN) && (w_fill < c_word_fill);
  assign w_accept       = bus.valid_i && w_ready;
  assign w_received_nxt = r_received + 32'(w_eff);
  assign w_addr         = ADDRESS_WIDTH'(32'(r_base) + 32'(r_word_cnt) * 32'(BUS_WIDTH_BYTES));

  // Lanes beyond the advertised count or past the end of the matrix are dropped.
  always_comb begin
    w_eff_cap = (32'(bus.cnt_i) > 32'(IN_LANES)) ? c_lanes : bus.cnt_i;
    if (32'(w_eff_cap) > w_remaining) begin
      w_eff_cap = w_remaining[c_cnt_w-1:0];
    end
    w_eff = w_accept ? w_eff_cap : '0;
  end

  // Pushing on the post-accept fill keeps the first push one cycle after its beat.
  always_comb begin
    w_push = 1'b0;
    if (!bus.fifo_full_i) begin
      if (r_state == RUN) begin
        w_push = (w_fill_sum >= c_word_fill);
      end else if (r_state == FLUSH) begin
        w_push = (w_fill != '0);
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (bus.start_i) w_state_nxt = (w_start_total == 32'd0) ? DONE : RUN;
      RUN:     if (w_received_nxt == r_total) w_state_nxt = (w_fill_nxt == '0) ? DONE : FLUSH;
      FLUSH:   if (w_fill_nxt == '0) w_state_nxt = DONE;
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  c_word_packer #(
    .ELEM_WIDTH (ELEM_WIDTH),
    .IN_LANES   (IN_LANES),
    .WORD_ELEMS (c_word_elems),
    .CNT_W      (c_cnt_w),
    .FILL_W     (c_fill_w)
  ) u_packer (
    .clk      (clk),
    .reset    (reset),
    .clear    (w_start),
    .data_in  (bus.data_i),
    .eff      (w_eff),
    .push     (w_push),
    .fill     (w_fill),
    .fill_sum (w_fill_sum),
    .fill_nxt (w_fill_nxt),
    .word     (w_word)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= IDLE;
      r_total    <= '0;
      r_received <= '0;
      r_base     <= '0;
      r_word_cnt <= '0;
      r_incr     <= 1'b0;
      r_done     <= 1'b0;
      r_addr     <= '0;
      r_data     <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_incr  <= w_push;
      // Registered from DONE so the pulse lands one cycle after the last strobe.
      r_done  <= (r_state == DONE);
      if (w_start) begin
        r_total    <= w_start_total;
        r_base     <= bus.base_addr_c;
        r_received <= '0;
        r_word_cnt <= '0;
      end else begin
        r_received <= w_received_nxt;
        if (w_push) begin
          r_word_cnt <= r_word_cnt + 16'd1;
        end
      end
      if (w_push) begin
        r_addr <= w_addr;
        r_data <= w_word;
      end
    end
  end

  assign bus.ready_o     = w_ready;
  assign bus.fifo_addr_o = r_addr;
  assign bus.fifo_data_o = r_data;
  assign bus.fifo_incr_o = r_incr;
  assign bus.busy_o      = (r_state != IDLE);
  assign bus.done_o      = r_done;

endmodule

`default_nettype wire
